// File: rtl/command_merge_inex.sv
// command_merge_inex
// Return-path merge for local-access command acknowledgements. Four sources
// (HCP, TSS/TSE 1..3) each feed a small FIFO; a round-robin arbiter drains
// them into one registered 66-bit stream. Each word is re-tagged with its
// 2-bit source ID in [63:62], and the displaced bits move up to [65:64].
// Pushes that hit a full FIFO are dropped and latch a sticky per-source flag.

module command_merge_inex #(
   parameter int FIFO_DEPTH = 4,
   parameter int FIFO_AW    = 2
) (
   input  logic        i_clk,
   input  logic        i_rst_n,
   input  logic [63:0] iv_hcp_command_ack,
   input  logic        i_hcp_command_ack_wr,
   input  logic [63:0] iv_tsstse_command_ack_1,
   input  logic        i_tsstse_command_ack_wr_1,
   input  logic [63:0] iv_tsstse_command_ack_2,
   input  logic        i_tsstse_command_ack_wr_2,
   input  logic [63:0] iv_tsstse_command_ack_3,
   input  logic        i_tsstse_command_ack_wr_3,
   input  logic        i_command_ack_ready,
   output logic [65:0] ov_command_ack,
   output logic        o_command_ack_wr,
   output logic [3:0]  ov_overflow_flag
);

   localparam int NSRC = 4;
   localparam logic [FIFO_AW:0] DEPTH_C = (FIFO_AW + 1)'(FIFO_DEPTH);

   logic [63:0]     din [NSRC];
   logic [63:0]     head [NSRC];
   logic [NSRC-1:0] push_req;
   logic [NSRC-1:0] nonempty;
   logic [NSRC-1:0] full;
   logic [NSRC-1:0] accept;
   logic [NSRC-1:0] drop;
   logic [NSRC-1:0] pop;

   logic [1:0]  last_grant_q, last_grant_d;
   logic        grant_vld;
   logic [1:0]  grant_id;
   logic [1:0]  idx;
   logic [65:0] ack_q, ack_d;
   logic        ack_wr_q, ack_wr_d;
   logic [3:0]  ovf_q, ovf_d;

   // Source index doubles as the ID placed in the merged word.
   assign din[0]      = iv_hcp_command_ack;
   assign din[1]      = iv_tsstse_command_ack_1;
   assign din[2]      = iv_tsstse_command_ack_2;
   assign din[3]      = iv_tsstse_command_ack_3;
   assign push_req[0] = i_hcp_command_ack_wr;
   assign push_req[1] = i_tsstse_command_ack_wr_1;
   assign push_req[2] = i_tsstse_command_ack_wr_2;
   assign push_req[3] = i_tsstse_command_ack_wr_3;

   for (genvar g = 0; g < NSRC; g++) begin : g_fifo
      logic [63:0]        mem_q [FIFO_DEPTH];
      logic [FIFO_AW-1:0] wr_ptr_q, rd_ptr_q;
      logic [FIFO_AW:0]   cnt_q, cnt_d;

      assign nonempty[g] = (cnt_q != '0);
      assign full[g]     = (cnt_q == DEPTH_C);
      // A pop in the same cycle frees the slot, so a push to a full FIFO
      // is only dropped when this source is not being drained.
      assign accept[g]   = push_req[g] & (~full[g] | pop[g]);
      assign drop[g]     = push_req[g] & full[g] & ~pop[g];
      assign head[g]     = mem_q[rd_ptr_q];

      // Occupancy next-state from accepted push and granted pop.
      always_comb begin
         cnt_d = cnt_q;
         case ({accept[g], pop[g]})
            2'b10:   cnt_d = cnt_q + 1'b1;
            2'b01:   cnt_d = cnt_q - 1'b1;
            default: cnt_d = cnt_q;
         endcase
      end

      // Storage array; contents are don't-care while empty, so no reset.
      always_ff @(posedge i_clk) begin
         if (accept[g]) begin
            mem_q[wr_ptr_q] <= din[g];
         end
      end

      // Pointers and occupancy; reset discards anything buffered.
      always_ff @(posedge i_clk or negedge i_rst_n) begin
         if (!i_rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
         end else begin
            if (accept[g]) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop[g])    rd_ptr_q <= rd_ptr_q + 1'b1;
            cnt_q <= cnt_d;
         end
      end
   end

   // Round-robin search starting after the last grant; also builds the
   // registered output word and the sticky drop flags.
   always_comb begin
      grant_vld    = 1'b0;
      grant_id     = last_grant_q;
      idx          = '0;
      pop          = '0;
      last_grant_d = last_grant_q;
      ack_d        = '0;
      ack_wr_d     = 1'b0;
      ovf_d        = ovf_q | drop;
      if (i_command_ack_ready) begin
         for (int k = 1; k <= NSRC; k++) begin
            idx = last_grant_q + 2'(k);
            if (!grant_vld && nonempty[idx]) begin
               grant_vld = 1'b1;
               grant_id  = idx;
            end
         end
      end
      if (grant_vld) begin
         pop          = 4'b0001 << grant_id;
         last_grant_d = grant_id;
         ack_d        = {head[grant_id][63:62], grant_id, head[grant_id][61:0]};
         ack_wr_d     = 1'b1;
      end
   end

   // Output register, last-grant pointer and flags. Last grant resets to 3
   // so HCP is searched first.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         last_grant_q <= 2'd3;
         ack_q        <= '0;
         ack_wr_q     <= 1'b0;
         ovf_q        <= '0;
      end else begin
         last_grant_q <= last_grant_d;
         ack_q        <= ack_d;
         ack_wr_q     <= ack_wr_d;
         ovf_q        <= ovf_d;
      end
   end

   assign ov_command_ack   = ack_q;
   assign o_command_ack_wr = ack_wr_q;
   assign ov_overflow_flag = ovf_q;

endmodule

// File: tb/tb_command_merge_inex.sv
// Directed bench for command_merge_inex. Inputs are driven and outputs
// sampled on the falling edge; expected words are hand-computed re-tags.

module tb_command_merge_inex;

   logic        clk;
   logic        rst_n;
   logic [63:0] hcp_d, t1_d, t2_d, t3_d;
   logic        hcp_wr, t1_wr, t2_wr, t3_wr;
   logic        ready;
   logic [65:0] ack;
   logic        ack_wr;
   logic [3:0]  ovf;

   int checks;
   int failures;

   command_merge_inex #(.FIFO_DEPTH(4), .FIFO_AW(2)) dut (
      .i_clk                    (clk),
      .i_rst_n                  (rst_n),
      .iv_hcp_command_ack       (hcp_d),
      .i_hcp_command_ack_wr     (hcp_wr),
      .iv_tsstse_command_ack_1  (t1_d),
      .i_tsstse_command_ack_wr_1(t1_wr),
      .iv_tsstse_command_ack_2  (t2_d),
      .i_tsstse_command_ack_wr_2(t2_wr),
      .iv_tsstse_command_ack_3  (t3_d),
      .i_tsstse_command_ack_wr_3(t3_wr),
      .i_command_ack_ready      (ready),
      .ov_command_ack           (ack),
      .o_command_ack_wr         (ack_wr),
      .ov_overflow_flag         (ovf)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [65:0] obs, input logic [65:0] exp);
      checks++;
      if (obs !== exp) begin
         failures++;
         $display("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic cyc();
      @(negedge clk);
   endtask

   task automatic clr_wr();
      hcp_wr = 1'b0; t1_wr = 1'b0; t2_wr = 1'b0; t3_wr = 1'b0;
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      #1;
      chk("rst_ack", ack, 66'h0);
      chk("rst_wr", {65'h0, ack_wr}, 66'h0);
      chk("rst_ovf", {62'h0, ovf}, 66'h0);
      cyc();
      rst_n = 1'b1;
      cyc();
   endtask

   initial begin
      checks = 0; failures = 0;
      rst_n = 1'b1; ready = 1'b1;
      hcp_d = '0; t1_d = '0; t2_d = '0; t3_d = '0;
      clr_wr();
      cyc();
      do_reset();

      // single HCP word: visible one edge after the push edge
      hcp_d = 64'hC123_4567_89AB_CDEF; hcp_wr = 1'b1;
      cyc();
      clr_wr();
      chk("t1_not_same_cycle", {65'h0, ack_wr}, 66'h0);
      cyc();
      chk("t1_ack", ack, 66'h3_0123_4567_89AB_CDEF);
      chk("t1_wr", {65'h0, ack_wr}, 66'h1);
      cyc();
      chk("t1_wr_after", {65'h0, ack_wr}, 66'h0);
      chk("t1_ack_idle", ack, 66'h0);

      // four simultaneous pushes, fresh round-robin pointer
      do_reset();
      hcp_d = 64'h1; t1_d = 64'h2; t2_d = 64'h3; t3_d = 64'h4;
      hcp_wr = 1'b1; t1_wr = 1'b1; t2_wr = 1'b1; t3_wr = 1'b1;
      cyc();
      clr_wr();
      cyc(); chk("t2_hcp", ack, 66'h0_0000_0000_0000_0001);
      cyc(); chk("t2_tss1", ack, 66'h0_4000_0000_0000_0002);
      cyc(); chk("t2_tss2", ack, 66'h0_8000_0000_0000_0003);
      cyc(); chk("t2_tss3", ack, 66'h0_C000_0000_0000_0004);
      cyc(); chk("t2_idle_wr", {65'h0, ack_wr}, 66'h0);

      // TSS2 overflow with ready low
      do_reset();
      ready = 1'b0;
      for (int i = 0; i < 6; i++) begin
         t2_d = 64'hA0 + 64'(i); t2_wr = 1'b1;
         cyc();
      end
      clr_wr();
      chk("t3_flag", {62'h0, ovf}, 66'h4);
      chk("t3_no_wr_while_stalled", {65'h0, ack_wr}, 66'h0);
      ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         cyc();
         chk("t3_word", ack, 66'h0_8000_0000_0000_00A0 + 66'(i));
      end
      cyc();
      chk("t3_drained", {65'h0, ack_wr}, 66'h0);
      chk("t3_flag_sticky", {62'h0, ovf}, 66'h4);

      // round-robin between HCP and TSS3 with a stall mid-stream
      do_reset();
      ready = 1'b0;
      for (int i = 0; i < 4; i++) begin
         hcp_d = 64'h100 + 64'(i); t3_d = 64'h200 + 64'(i);
         hcp_wr = 1'b1; t3_wr = 1'b1;
         cyc();
      end
      clr_wr();
      ready = 1'b1;
      for (int i = 0; i < 2; i++) begin
         cyc(); chk("t4_hcp_a", ack, 66'h0_0000_0000_0000_0100 + 66'(i));
         cyc(); chk("t4_tss3_a", ack, 66'h0_C000_0000_0000_0200 + 66'(i));
      end
      ready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         cyc(); chk("t4_stall_wr", {65'h0, ack_wr}, 66'h0);
      end
      ready = 1'b1;
      for (int i = 2; i < 4; i++) begin
         cyc(); chk("t4_hcp_b", ack, 66'h0_0000_0000_0000_0100 + 66'(i));
         cyc(); chk("t4_tss3_b", ack, 66'h0_C000_0000_0000_0200 + 66'(i));
      end
      chk("t4_no_flag", {62'h0, ovf}, 66'h0);

      // reset while words are buffered (and a flag is set)
      do_reset();
      ready = 1'b0;
      for (int i = 0; i < 5; i++) begin
         hcp_d = 64'h500 + 64'(i); hcp_wr = 1'b1;
         cyc();
      end
      clr_wr();
      ready = 1'b1;
      cyc();
      chk("t5_pre_ack", ack, 66'h0_0000_0000_0000_0500);
      chk("t5_pre_flag", {62'h0, ovf}, 66'h1);
      do_reset();
      for (int i = 0; i < 10; i++) begin
         chk("t5_post_wr", {65'h0, ack_wr}, 66'h0);
         cyc();
      end

      // full FIFO with push and pop on the same edge
      do_reset();
      ready = 1'b0;
      for (int i = 0; i < 4; i++) begin
         t1_d = 64'h300 + 64'(i); t1_wr = 1'b1;
         cyc();
      end
      ready = 1'b1;
      t1_d = 64'h304; t1_wr = 1'b1;
      cyc();
      clr_wr();
      chk("t6_first", ack, 66'h0_4000_0000_0000_0300);
      chk("t6_no_flag", {62'h0, ovf}, 66'h0);
      for (int i = 1; i < 5; i++) begin
         cyc();
         chk("t6_word", ack, 66'h0_4000_0000_0000_0300 + 66'(i));
      end
      cyc();
      chk("t6_drained", {65'h0, ack_wr}, 66'h0);
      chk("t6_flag_end", {62'h0, ovf}, 66'h0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/command_merge_inex.md
Name: command_merge_inex

Overview:
- Return-path counterpart of the local-access command parser.
- Collects 64-bit command acknowledgements from four local targets: HCP, TSS/TSE instance 1, instance 2 and instance 3.
- Re-tags each acknowledgement with its 2-bit source ID in bits [63:62] and restores the displaced bits to [65:64].
- Merges the four streams through per-source FIFOs and a round-robin arbiter into one 66-bit stream toward the TSMP encapsulation logic.

Parameters:
- FIFO_DEPTH, 4, entries per source FIFO (power of two, ≥2).
- FIFO_AW, 2, log2(FIFO_DEPTH); FIFO pointer width.

Ports:
- i_clk  input  1  system clock.
- i_rst_n  input  1  asynchronous active-low reset.
- iv_hcp_command_ack  input  64  acknowledgement word from HCP.
- i_hcp_command_ack_wr  input  1  single-cycle write strobe for iv_hcp_command_ack.
- iv_tsstse_command_ack_1  input  64  acknowledgement word from TSS/TSE 1.
- i_tsstse_command_ack_wr_1  input  1  write strobe for source 1.
- iv_tsstse_command_ack_2  input  64  acknowledgement word from TSS/TSE 2.
- i_tsstse_command_ack_wr_2  input  1  write strobe for source 2.
- iv_tsstse_command_ack_3  input  64  acknowledgement word from TSS/TSE 3.
- i_tsstse_command_ack_wr_3  input  1  write strobe for source 3.
- i_command_ack_ready  input  1  downstream may accept a word this cycle.
- ov_command_ack  output  66  merged, re-tagged acknowledgement.
- o_command_ack_wr  output  1  single-cycle valid for ov_command_ack.
- ov_overflow_flag  output  4  sticky per-source drop flags: bit0 HCP, bit1..3 TSS/TSE 1..3.

Behaviour:
- Reset (async, i_rst_n=0), all asserted immediately:
  - ov_command_ack=66'b0, o_command_ack_wr=0, ov_overflow_flag=4'b0.
  - All FIFO pointers and counts = 0.
  - Round-robin last-grant pointer = 2'd3, so HCP has first priority.
- Reset mid-operation discards all buffered words.
- Source IDs: HCP=2'b00, TSS/TSE1=2'b01, TSS/TSE2=2'b10, TSS/TSE3=2'b11.
- Re-tag rule, for input word w from source s:
  - ov_command_ack = {w[63:62], s, w[61:0]}.
  - This is the exact inverse of the forward parser's split.
- Push:
  - At each rising edge where wr=1, the word is written into that source's FIFO.
  - All four sources may push in the same cycle.
- Full: a push to a full FIFO is dropped and sets that source's ov_overflow_flag bit. The bit stays sticky until reset.
- Simultaneous push and pop on a full FIFO: the push is accepted, with no drop and no flag.
- Arbitration (every edge):
  - Requires i_command_ack_ready=1 and at least one non-empty FIFO.
  - Grant goes to the first non-empty source searching from last_grant+1, wrapping 3→0.
  - The granted FIFO is popped and last_grant updated.
  - The output is registered: ov_command_ack = re-tagged head word and o_command_ack_wr=1 for exactly one cycle.
- Idle: with no grant, o_command_ack_wr=0 and ov_command_ack=66'b0.
- Flow control: with i_command_ack_ready=0, no pop occurs and last_grant is held. Words are never lost except on overflow.
- Latency: a word pushed at edge k into an empty FIFO, with ready=1 and no competing source, is output after edge k+1. It is not visible in the same cycle as its push.
- Throughput: one word per cycle aggregate.
- Per-source order is preserved (FIFO). Cross-source order follows round-robin only.
- FIFO pointers wrap modulo FIFO_DEPTH. Count range is 0..FIFO_DEPTH.

Test Plan:
- HCP word 64'hC123_4567_89AB_CDEF, wr=1 for one cycle, ready=1:
  - Two edges later: ov_command_ack=66'h3_0123_4567_89AB_CDEF, wr=1 for one cycle.
  - All other cycles: wr=0.
- All four sources push in the same cycle; words 64'h0…01, 64'h0…02, 64'h0…03, 64'h0…04; ready=1:
  - Outputs on four consecutive cycles, in order HCP, TSS1, TSS2, TSS3.
  - Bits [63:62] = 00, 01, 10, 11 respectively.
- TSS2 pushes 6 words back-to-back with ready=0 (FIFO_DEPTH=4):
  - ov_overflow_flag=4'b0100.
  - After ready=1: exactly words 1–4 emerge in order.
  - Flag remains set.
- Round-robin fairness: HCP and TSS3 both kept non-empty, ready=1:
  - Grants alternate HCP, TSS3, HCP, TSS3…
  - Ready dropped for 3 cycles mid-stream: no wr, alternation resumes where it stopped.
- Reset pulse while 3 words are buffered:
  - Outputs are 0 immediately.
  - After release with no new input, o_command_ack_wr stays 0 for 10 cycles.
- Full FIFO (4 words, ready=1) plus a push in the same cycle as a pop:
  - Push accepted, no flag set.
  - All 5 words emerge in order.
